// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register write arbiter:
// FSM state encoding, a clog2 helper and the DIN slicing convention.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Number of bits needed to index v distinct values.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Requester idx owns DIN[idx*wdt +: wdt].
  function automatic int unsigned din_lsb(input int unsigned idx, input int unsigned wdt);
    return idx * wdt;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Request/data/result bundle of the shared-register arbiter.
//   master : producer side (drives REQ, LOCK, DIN; reads Q, GNT, OWNER, BUSY)
//   slave  : arbiter side
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned WDT = 7
) ();
  localparam int unsigned IW = clog2(N);

  logic [N-1:0]     REQ;
  logic [N-1:0]     LOCK;
  logic [N*WDT-1:0] DIN;
  logic [WDT-1:0]   Q;
  logic [N-1:0]     GNT;
  logic [IW-1:0]    OWNER;
  logic             BUSY;

  modport master (output REQ, LOCK, DIN, input Q, GNT, OWNER, BUSY);
  modport slave  (input REQ, LOCK, DIN, output Q, GNT, OWNER, BUSY);
endinterface

// File: rtl/shared_reg_arbiter_dtr.sv
// Enable register with asynchronous active-high reset to zero.
//   CLK, RST : clock / reset
//   EN       : load strobe
//   D, Q     : data in / stored value
module dtr #(
  parameter int unsigned W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     Q <= '0;
    else if (EN) Q <= D;
  end
endmodule

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req_i   : request vector
//   ptr_i   : last served index; scanning starts at ptr_i+1 (mod N)
//   win_o   : first requesting index found
//   valid_o : any request present
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] win_o,
  output logic          valid_o
);
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[idx]) begin
        win_o   = IW'(idx);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared WDT-wide register, with an
// optional bounded ownership lock (at most MAX_HOLD consecutive grants).
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : slave side of shared_reg_arbiter_if (REQ, LOCK, DIN in;
//              Q, GNT, OWNER, BUSY out, all registered)
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WDT      = 7,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic             CLK,
  input logic             RST,
  shared_reg_arbiter_if.slave bus
);
  localparam int unsigned IW = clog2(N);
  localparam int unsigned CW = clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] owner_q, owner_d;

  logic [IW-1:0]  win;
  logic           win_valid;
  logic [IW-1:0]  sel;
  logic           wr_en;
  logic [WDT-1:0] wdata;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i   (bus.REQ),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .valid_o (win_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    owner_d = owner_q;
    sel     = owner_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          sel        = win;
          wr_en      = 1'b1;
          gnt_d[win] = 1'b1;
          owner_d    = win;
          ptr_d      = win;
          if (bus.LOCK[win]) begin
            state_d = OWN;
            cnt_d   = CW'(1);
          end
        end
      end
      OWN: begin
        // cnt counts OWN cycles including the grant cycle, so leaving at
        // MAX_HOLD-1 caps the burst at MAX_HOLD grants even if REQ idles.
        cnt_d = cnt_q + CW'(1);
        if (bus.REQ[owner_q]) begin
          wr_en          = 1'b1;
          gnt_d[owner_q] = 1'b1;
        end
        if (!bus.LOCK[owner_q] || cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    wdata = bus.DIN[din_lsb(32'(sel), WDT) +: WDT];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(N - 1);
      gnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
    end
  end

  dtr #(.W(WDT)) u_q_reg (
    .CLK (CLK),
    .RST (RST),
    .EN  (wr_en),
    .D   (wdata),
    .Q   (bus.Q)
  );

  assign bus.GNT   = gnt_q;
  assign bus.OWNER = owner_q;
  assign bus.BUSY  = (state_q == OWN);

endmodule
